mux_arb_reg: RTL and testbench
==============================

// Module: mux_arb_reg
// PURPOSE
//   Parametrised N-channel, WIDTH-bit selector with a registered output stage and
//   valid/ready handshakes on every input and on the output.
//   Two modes: explicit select (sel picks the channel) or round-robin arbitration.
//   Used where datapath sources must be merged across a pipeline boundary,
//   e.g. writeback and memory-response merging, without a combinational path to the sink.
// PARAMETERS
//   WIDTH  32  data width per channel, in bits
//   N      4   number of input channels, >= 2
//   SELW   2   select/channel-index width; must equal $clog2(N)
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   N        per-channel valid; bit i belongs to channel i
//   in_ready   out  N        per-channel ready; at most one bit high per cycle
//   in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   sel        in   SELW     channel select; used only when rr_mode=0
//   rr_mode    in   1        0 = explicit select, 1 = round-robin
//   out_valid  out  1        output register holds a word
//   out_ready  in   1        sink accepts the word
//   out_data   out  WIDTH    registered data
//   out_chan   out  SELW     index of the channel that out_data came from
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
//     While rst_n=0, in_ready is all 0. A held word is discarded.
//   accept = !out_valid || out_ready. This gives a one-entry pipeline with full throughput.
//   Grant g, combinational, evaluated every cycle:
//     rr_mode=0:
//       g=sel if sel<N and in_valid[sel]=1; otherwise no grant.
//       Other channels' valids are ignored.
//     rr_mode=1:
//       g = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
//       No grant if in_valid is all 0.
//   in_ready[i] = rst_n && accept && grant && (g==i).
//   Transfer = in_valid[g] && in_ready[g]. On the next edge:
//     out_valid=1, out_data=in_data[g], out_chan=g.
//   Latency: 1 cycle from input transfer to out_valid.
//   If out_valid=1 and out_ready=1 with no transfer, out_valid goes to 0 next edge.
//   If out_valid=1 and out_ready=0, out_data and out_chan hold; no input is accepted.
//   Simultaneous output drain and input transfer: the new word replaces the old
//     one in the same edge, with no bubble.
//   rr_ptr (SELW bits):
//     On a transfer in rr_mode=1, rr_ptr <= (g==N-1) ? 0 : g+1.
//     Otherwise rr_ptr holds; a transfer in select mode does not change it.
//   rr_mode and sel may change on any cycle; they take effect for that cycle's grant.
//     A held output word is never altered.
//   Inputs must hold in_valid/in_data until ready; dropping valid early is legal
//     and loses nothing, since no transfer occurs.
//   N not a power of 2: sel >= N yields no grant. rr_ptr never exceeds N-1.
// TESTING
//   1. Assert rst_n=0 mid-hold (out_valid=1, out_ready=0)
//      -> out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately (async);
//      after release, first RR grant goes to ch0.
//   2. rr_mode=0, sel=2, in_valid=4'b0101, in_data[2]=32'hDEADBEEF, out_ready=1
//      -> in_ready=4'b0100; next cycle out_valid=1, out_data=DEADBEEF, out_chan=2.
//   3. rr_mode=0, sel=1, in_valid=4'b1101 -> in_ready=0; out_valid stays 0.
//   4. out_ready=0 for 3 cycles with a held word and all inputs valid
//      -> out_data constant, in_ready=0.
//      Then out_ready=1 -> a new word loads on the same edge; out_valid never drops.
//   5. rr_mode=1, in_valid=4'b1111 constant, out_ready=1
//      -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles; one word per cycle.
//   6. rr_mode=1, in_valid=4'b1010 constant -> out_chan 1,3,1,3.
//      Then switch to rr_mode=0, sel=3 for 2 cycles, then back to rr_mode=1
//      -> rr_ptr was unchanged by the select-mode transfers.

Source files
------------

// File: rtl/mux_arb_reg.sv
// N-channel valid/ready selector with a registered output stage.
// Channels are chosen by explicit select or by round-robin arbitration.
module mux_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               rr_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan
);

  localparam int NEXT = 1 << SELW;

  logic [NEXT-1:0]  valid_ext;
  logic [SELW:0]    scan_idx;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             accept;
  logic             transfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  // Valids padded to the full select range, so an index >= N reads as "not valid".
  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = in_valid;
    grant_valid        = 1'b0;
    grant_idx          = sel;
    scan_idx           = '0;
    if (!rr_mode) begin
      grant_valid = valid_ext[sel];
    end else begin
      // Scan from the farthest offset down, so the offset closest to rr_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        scan_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (scan_idx >= (SELW+1)'(N)) scan_idx = scan_idx - (SELW+1)'(N);
        if (valid_ext[scan_idx[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = scan_idx[SELW-1:0];
        end
      end
    end
  end

  assign accept   = !out_valid_q || out_ready;
  assign transfer = grant_valid && accept;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && transfer && (grant_idx == SELW'(i));
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
      if (rr_mode) begin
        rr_ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: directed scenarios, then random traffic,
// all compared against a transaction-level model of the selector.
module tb_mux_arb_reg;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [WIDTH-1:0]   data_arr [N];
  logic [SELW-1:0]    sel;
  logic               rr_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;

  // Reference model state
  bit                 m_valid;
  logic [WIDTH-1:0]   m_data;
  int                 m_chan;
  int                 m_ptr;

  int vectors     = 0;
  int miscompares = 0;

  mux_arb_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = data_arr[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rr, input int s, input logic [N-1:0] v, input bit ordy);
    rr_mode   = rr;
    sel       = SELW'(s);
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
    check({tag, ".out_data"},  64'(out_data),  64'(m_data));
  endtask

  // One clock cycle: predict the grant from the current inputs, check in_ready,
  // clock the DUT, advance the model and compare the output register.
  task automatic cycle(input string tag);
    bit               gv;
    int               g;
    bit               acc;
    logic [N-1:0]     exp_ready;
    logic [WIDTH-1:0] word;
    gv = 0;
    g  = 0;
    if (!rr_mode) begin
      if (int'(sel) < N && in_valid[sel]) begin
        gv = 1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!gv && in_valid[(m_ptr + k) % N]) begin
          gv = 1;
          g  = (m_ptr + k) % N;
        end
      end
    end
    acc       = !m_valid || out_ready;
    exp_ready = (gv && acc) ? (N'(1) << g) : '0;
    word      = data_arr[g];
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    if (gv && acc) begin
      m_valid = 1;
      m_data  = word;
      m_chan  = g;
      if (rr_mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) data_arr[i] = 32'h1000_0000 + 32'(i);
    set_in(1, 0, 4'b1111, 1);
    model_reset();

    // Power-on reset: outputs cleared, no ready while in reset
    #1;
    check_outputs("por");
    check("por.in_ready", 64'(in_ready), 64'h0);
    #12 rst_n = 1'b1;

    // Explicit select of channel 2
    data_arr[2] = 32'hDEADBEEF;
    set_in(0, 2, 4'b0101, 1);
    cycle("sel2");
    check("sel2.data_const", 64'(out_data), 64'hDEADBEEF);
    check("sel2.chan_const", 64'(out_chan), 64'd2);

    // Selected channel not valid: no grant, output drains
    set_in(0, 1, 4'b1101, 1);
    cycle("sel1_nogrant_a");
    cycle("sel1_nogrant_b");

    // Backpressure with all inputs valid, then refill on the draining edge
    set_in(0, 0, 4'b1111, 1);
    cycle("bp_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("bp_hold");
    data_arr[2] = 32'hCAFE_F00D;
    set_in(0, 2, 4'b1111, 1);
    cycle("bp_release");
    check("bp_release.valid_const", 64'(out_valid), 64'h1);
    check("bp_release.chan_const",  64'(out_chan),  64'd2);

    // Round-robin over all channels from rr_ptr = 0
    set_in(1, 0, 4'b1111, 1);
    for (int i = 0; i < 6; i++) begin
      data_arr[i % N] = $urandom;
      cycle("rr_all");
      check("rr_all.seq", 64'(out_chan), 64'(i % N));
    end

    // Async reset in the middle of a held word
    set_in(0, 1, 4'b1111, 0);
    cycle("rst_load");
    cycle("rst_hold");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 0, 4'b1111, 1);
    cycle("rst_first_rr");
    check("rst_first_rr.chan0", 64'(out_chan), 64'd0);

    // Sparse round-robin, then select-mode transfers must not move rr_ptr
    set_in(1, 0, 4'b1010, 1);
    cycle("rr_sparse");
    check("rr_sparse.c0", 64'(out_chan), 64'd1);
    cycle("rr_sparse");
    check("rr_sparse.c1", 64'(out_chan), 64'd3);
    cycle("rr_sparse");
    check("rr_sparse.c2", 64'(out_chan), 64'd1);
    set_in(0, 3, 4'b1010, 1);
    cycle("sel3");
    cycle("sel3");
    set_in(1, 0, 4'b1010, 1);
    cycle("rr_resume");
    check("rr_resume.ptr_kept", 64'(out_chan), 64'd3);
    cycle("rr_resume");
    check("rr_resume.next", 64'(out_chan), 64'd1);

    // Random traffic in both modes with random backpressure
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) data_arr[c] = $urandom;
      set_in($urandom_range(0, 1), $urandom_range(0, N - 1),
             N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
